channel_select: RTL and testbench
=================================

Name: channel_select

Overview:
- Sits directly downstream of the channelizer and consumes its interleaved output stream.
- The input stream carries one sample per channel in order 0..N-1, and the channelizer flags channel 0 with first_channel.
- This block tracks frame alignment, extracts the single channel chosen by sel, and forwards it with its metadata as a decimated stream.
- It also reports alignment faults and passes through upstream errors.

Parameters:
N, 16, number of channels per frame (power of 2, >= 2)
LOGN, 4, log2(N); width of the channel index
WDTH, 32, sample width (complex, passed through untouched)
MWDTH, 1, metadata width (passed through untouched)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  WDTH  channelizer sample
in_nd  input  1  in_data/in_m/in_first valid this cycle
in_m  input  MWDTH  metadata accompanying in_data
in_first  input  1  sample is channel 0 (qualified by in_nd)
in_error  input  1  upstream error flag
sel  input  LOGN  requested channel index
out_data  output  WDTH  selected-channel sample
out_nd  output  1  out_data/out_m valid (one-cycle pulse)
out_m  output  MWDTH  metadata of selected sample
locked  output  1  frame alignment held
error  output  1  sticky fault flag

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state=SEARCH, count=0, active_sel=0. Reset mid-frame discards alignment; the block re-acquires on the next in_first.
- Cycles with in_nd=0 change nothing except out_nd, which returns to 0.
- State SEARCH (locked=0):
  - in_nd=1, in_first=0: sample dropped, no error.
  - in_nd=1, in_first=1: latch active_sel<=sel, count<=1, go to LOCKED. The sample is index 0 and is emitted if sel==0 (uses the newly latched value).
- State LOCKED (locked=1). count holds the expected index of the next sample. On in_nd=1:
  - in_first=1, count==0: normal frame start. Latch active_sel<=sel, idx=0, count<=1.
  - in_first=1, count!=0: early frame. error<=1, resync as a normal frame start (idx=0, relatch sel, count<=1). Stay in LOCKED.
  - in_first=0, count==0: missing marker. error<=1, go to SEARCH, drop the sample, count<=0.
  - in_first=0, count!=0: idx=count, count<=count+1 (LOGN-bit natural wrap N-1 -> 0).
- Emission:
  - Applies when the sample is accepted (not dropped) and idx==active_sel.
  - Next cycle: out_nd=1, out_data<=in_data, out_m<=in_m.
  - Otherwise out_nd=0, and out_data/out_m hold their last values.
- Latency: exactly 1 clock from in_nd to out_nd. Output rate = input rate / N in steady state.
- sel changes take effect only at a frame start (in_first accepted), so a frame never mixes channels. sel is sampled in that same cycle.
- in_error=1 in any cycle sets error<=1.
- error is sticky until reset, registered, and visible one cycle after its cause.
- Consecutive in_nd cycles (back-to-back samples) must be supported with no bubbles required.
- N=2 corner case: count toggles 0/1. Every rule above holds.

Test Plan:
1. Reset, then two frames of N=16 samples (data = 100*frame+idx, in_first on idx 0), sel=5 -> exactly two out_nd pulses carrying data 5 and 105, each 1 cycle after the input; error=0, locked=1 after the first in_first.
2. Samples before the first in_first (idx 9..15) with sel=12 -> no out_nd, locked=0. Then one full frame -> single output of idx 12.
3. sel=3 in frame 0; sel changed to 7 mid-frame 0 at idx 5; frame 1 -> outputs idx 3 of frame 0 and idx 7 of frame 1 only.
4. Inject in_first at idx 10 of frame 0 (sel=2) -> error=1 next cycle, block resyncs, and the following samples are treated as idx 0.. with idx 2 emitted from the resynced frame; locked stays 1.
5. Drop in_first on frame 1's first sample -> error=1, locked=0, no output until the next in_first; then the sel channel is emitted normally. Assert rst_n=0 mid-frame -> all outputs 0 immediately; error clears.
6. Gapped input (in_nd every 3rd cycle), sel=15, plus a single in_error pulse -> idx-15 output one cycle after its in_nd, and error=1 persists until reset.

Source files
------------

// File: rtl/channel_select.sv
// Channel selector for an interleaved channelizer stream: tracks frame alignment,
// extracts the channel chosen by sel once per frame, and flags alignment faults.
module channel_select #(
  parameter int N     = 16,
  parameter int LOGN  = 4,
  parameter int WDTH  = 32,
  parameter int MWDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WDTH-1:0]  in_data,
  input  logic             in_nd,
  input  logic [MWDTH-1:0] in_m,
  input  logic             in_first,
  input  logic             in_error,
  input  logic [LOGN-1:0]  sel,
  output logic [WDTH-1:0]  out_data,
  output logic             out_nd,
  output logic [MWDTH-1:0] out_m,
  output logic             locked,
  output logic             error
);

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [LOGN-1:0] LAST_IDX = LOGN'(N - 1);

  state_t            state_r, state_nxt_s;
  logic [LOGN-1:0]   count_r, count_nxt_s;
  logic [LOGN-1:0]   active_sel_r, active_sel_nxt_s;
  logic [LOGN-1:0]   idx_s;
  logic              accept_s;
  logic              emit_s;
  logic              err_set_s;

  logic [WDTH-1:0]   out_data_r;
  logic              out_nd_r;
  logic [MWDTH-1:0]  out_m_r;
  logic              locked_r;
  logic              error_r;

  // Next-state, sample index and fault decode for one accepted input beat.
  always_comb begin
    state_nxt_s      = state_r;
    count_nxt_s      = count_r;
    active_sel_nxt_s = active_sel_r;
    idx_s            = count_r;
    accept_s         = 1'b0;
    err_set_s        = in_error;
    if (in_nd) begin
      case (state_r)
        SEARCH: begin
          if (in_first) begin
            active_sel_nxt_s = sel;
            idx_s            = {LOGN{1'b0}};
            count_nxt_s      = LOGN'(1);
            accept_s         = 1'b1;
            state_nxt_s      = LOCKED;
          end else begin
            accept_s = 1'b0;
          end
        end
        LOCKED: begin
          if (in_first) begin
            // An early marker is a fault but still restarts the frame here.
            if (count_r != {LOGN{1'b0}}) begin
              err_set_s = 1'b1;
            end else begin
              err_set_s = in_error;
            end
            active_sel_nxt_s = sel;
            idx_s            = {LOGN{1'b0}};
            count_nxt_s      = LOGN'(1);
            accept_s         = 1'b1;
          end else if (count_r == {LOGN{1'b0}}) begin
            err_set_s   = 1'b1;
            count_nxt_s = {LOGN{1'b0}};
            state_nxt_s = SEARCH;
          end else begin
            idx_s       = count_r;
            count_nxt_s = (count_r == LAST_IDX) ? {LOGN{1'b0}} : count_r + LOGN'(1);
            accept_s    = 1'b1;
          end
        end
        default: begin
          state_nxt_s = SEARCH;
          count_nxt_s = {LOGN{1'b0}};
        end
      endcase
    end else begin
      accept_s = 1'b0;
    end
  end

  // Frame starts compare against the freshly latched selection.
  assign emit_s = accept_s && (idx_s == active_sel_nxt_s);

  // Alignment tracking registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= SEARCH;
      count_r      <= {LOGN{1'b0}};
      active_sel_r <= {LOGN{1'b0}};
      locked_r     <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      count_r      <= count_nxt_s;
      active_sel_r <= active_sel_nxt_s;
      locked_r     <= (state_nxt_s == LOCKED);
    end
  end

  // Output sample registers; data and metadata hold between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r <= {WDTH{1'b0}};
      out_m_r    <= {MWDTH{1'b0}};
      out_nd_r   <= 1'b0;
    end else begin
      out_nd_r <= emit_s;
      if (emit_s) begin
        out_data_r <= in_data;
        out_m_r    <= in_m;
      end
    end
  end

  // Sticky fault flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_r <= 1'b0;
    end else begin
      error_r <= error_r | err_set_s;
    end
  end

  assign out_data = out_data_r;
  assign out_nd   = out_nd_r;
  assign out_m    = out_m_r;
  assign locked   = locked_r;
  assign error    = error_r;

endmodule

// File: tb/tb_channel_select.sv
// Scoreboard bench for channel_select: expected samples are queued when driven
// and checked (value and one-cycle latency) when out_nd pulses.
module tb_channel_select;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_nd = 1'b0;
  logic [0:0]  in_m = 1'b0;
  logic        in_first = 1'b0;
  logic        in_error = 1'b0;
  logic [3:0]  sel = 4'd0;
  logic [31:0] out_data;
  logic        out_nd;
  logic [0:0]  out_m;
  logic        locked;
  logic        error;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [32:0] exp_q[$];
  int          exp_cyc_q[$];

  channel_select #(.N(16), .LOGN(4), .WDTH(32), .MWDTH(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_nd(in_nd), .in_m(in_m),
    .in_first(in_first), .in_error(in_error), .sel(sel), .out_data(out_data),
    .out_nd(out_nd), .out_m(out_m), .locked(locked), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n && out_nd) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_out: got data=%0d, required no output", out_data);
      end else begin
        logic [32:0] e;
        int ec;
        e = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        if ({out_m, out_data} !== e || cyc !== ec) begin
          errors = errors + 1;
          $display("FAIL out_sample: got data=%0d m=%0d cyc=%0d, required data=%0d m=%0d cyc=%0d",
                   out_data, out_m, cyc, e[31:0], e[32], ec);
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic f, input logic expect_out);
    @(negedge clk);
    in_data = d; in_first = f; in_nd = 1'b1; in_m = d[0:0];
    if (expect_out) begin
      exp_q.push_back({d[0:0], d});
      exp_cyc_q.push_back(cyc + 1);
    end
    @(posedge clk); #1;
    in_nd = 1'b0; in_first = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_nd = 1'b0; in_first = 1'b0; in_error = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks = checks + 1;
    if ({out_nd, out_data, out_m, locked, error} !== 36'd0) begin
      errors = errors + 1;
      $display("FAIL reset_state: got nd=%0b data=%0d m=%0b locked=%0b error=%0b, required all 0",
               out_nd, out_data, out_m, locked, error);
    end
  endtask

  task automatic test_two_frames();
    do_reset();
    sel = 4'd5;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 16; i++) begin
        send(32'(100 * f + i), (i == 0), (i == 5));
        if (f == 0 && i == 0) begin
          checks = checks + 1;
          if (locked !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL lock_after_first: got locked=%0b, required 1", locked);
          end
        end
      end
    end
    idle(2);
    checks = checks + 1;
    if (error !== 1'b0 || exp_q.size() !== 0) begin
      errors = errors + 1;
      $display("FAIL two_frames_end: got error=%0b pending=%0d, required 0 and 0", error, exp_q.size());
    end
  endtask

  task automatic test_search_drop();
    do_reset();
    sel = 4'd12;
    for (int i = 9; i < 16; i++) send(32'(i), 1'b0, 1'b0);
    checks = checks + 1;
    if (locked !== 1'b0 || error !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL search_drop: got locked=%0b error=%0b, required 0 and 0", locked, error);
    end
    for (int i = 0; i < 16; i++) send(32'(200 + i), (i == 0), (i == 12));
    idle(2);
    checks = checks + 1;
    if (exp_q.size() !== 0) begin
      errors = errors + 1;
      $display("FAIL search_frame: got pending=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_sel_change();
    do_reset();
    sel = 4'd3;
    for (int i = 0; i < 16; i++) begin
      if (i == 5) sel = 4'd7;
      send(32'(300 + i), (i == 0), (i == 3));
    end
    for (int i = 0; i < 16; i++) send(32'(400 + i), (i == 0), (i == 7));
    idle(2);
    checks = checks + 1;
    if (exp_q.size() !== 0 || error !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL sel_change: got pending=%0d error=%0b, required 0 and 0", exp_q.size(), error);
    end
  endtask

  task automatic test_early_first();
    do_reset();
    sel = 4'd2;
    for (int i = 0; i < 10; i++) send(32'(500 + i), (i == 0), (i == 2));
    checks = checks + 1;
    if (error !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL early_pre: got error=%0b, required 0", error);
    end
    send(32'd1000, 1'b1, 1'b0);
    checks = checks + 1;
    if (error !== 1'b1 || locked !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL early_first: got error=%0b locked=%0b, required 1 and 1", error, locked);
    end
    for (int i = 1; i < 16; i++) send(32'(1000 + i), 1'b0, (i == 2));
    idle(2);
    checks = checks + 1;
    if (exp_q.size() !== 0 || locked !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL early_resync: got pending=%0d locked=%0b, required 0 and 1", exp_q.size(), locked);
    end
  endtask

  task automatic test_missing_first();
    do_reset();
    sel = 4'd4;
    for (int i = 0; i < 16; i++) send(32'(600 + i), (i == 0), (i == 4));
    send(32'd700, 1'b0, 1'b0);
    checks = checks + 1;
    if (error !== 1'b1 || locked !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL missing_first: got error=%0b locked=%0b, required 1 and 0", error, locked);
    end
    for (int i = 1; i < 16; i++) send(32'(700 + i), 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) send(32'(800 + i), (i == 0), (i == 4));
    for (int i = 0; i < 7; i++) send(32'(901 + 2 * i), (i == 0), (i == 4));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks = checks + 1;
    if ({out_nd, out_data, out_m, locked, error} !== 36'd0 || exp_q.size() !== 0) begin
      errors = errors + 1;
      $display("FAIL midframe_reset: got nd=%0b data=%0d m=%0b locked=%0b error=%0b pending=%0d, required all 0",
               out_nd, out_data, out_m, locked, error, exp_q.size());
    end
    idle(1);
    rst_n = 1'b1;
    for (int i = 7; i < 16; i++) send(32'(901 + 2 * i), 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) send(32'(1100 + i), (i == 0), (i == 4));
    idle(2);
    checks = checks + 1;
    if (exp_q.size() !== 0 || error !== 1'b0 || locked !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL reacquire: got pending=%0d error=%0b locked=%0b, required 0, 0, 1",
               exp_q.size(), error, locked);
    end
  endtask

  task automatic test_gapped_error();
    do_reset();
    sel = 4'd15;
    for (int i = 0; i < 16; i++) begin
      send(32'(1200 + i), (i == 0), (i == 15));
      if (i == 6) begin
        @(negedge clk); in_error = 1'b1;
        @(posedge clk); #1; in_error = 1'b0;
        checks = checks + 1;
        if (error !== 1'b1) begin
          errors = errors + 1;
          $display("FAIL in_error_set: got error=%0b, required 1", error);
        end
      end else begin
        idle(2);
      end
    end
    idle(4);
    checks = checks + 1;
    if (error !== 1'b1 || exp_q.size() !== 0) begin
      errors = errors + 1;
      $display("FAIL error_sticky: got error=%0b pending=%0d, required 1 and 0", error, exp_q.size());
    end
    do_reset();
    checks = checks + 1;
    if (error !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL error_cleared: got error=%0b, required 0", error);
    end
  endtask

  initial begin
    test_reset();
    test_two_frames();
    test_search_drop();
    test_sel_change();
    test_early_first();
    test_missing_first();
    test_gapped_error();
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
